rs_syndrome_engine: RTL and testbench
=====================================

Name: rs_syndrome_engine

Overview:
Parametrised Reed-Solomon syndrome calculator, the successor to the fixed RS(255,239) syndrome block. It accepts received symbols with a valid/start-of-frame qualifier and computes 2T syndromes by Horner iteration. Completed syndromes go into a double-buffered output bank and are streamed serially, with ready/valid backpressure, to the key-equation solver. The next frame accumulates while the previous one streams out, and each frame carries an error-free flag.

Parameters:
N, 255, codeword length in symbols (2 <= N <= 2^M-1)
K, 239, message length; 2T = N-K; checked at elaboration
M, 8, symbol width in bits
FCR, 0, first consecutive root exponent; S_j uses root alpha^(FCR+j-1), j=1..2T
PRIM_POLY, 9'h11D, field primitive polynomial, M+1 bits

Ports:
clk_in  in  1  system clock
rst_n  in  1  reset; asynchronous assert, active-low
data_valid  in  1  data_in holds a symbol this cycle
data_sof  in  1  first symbol of frame; sampled only when data_valid=1
data_in  in  M  received symbol, highest-degree coefficient first
synd_valid  out  1  synd_out valid
synd_ready  in  1  downstream accepts the syndrome this cycle
synd_out  out  M  current syndrome
synd_idx  out  ceil(log2(2T))  index j-1 of synd_out
synd_last  out  1  synd_out is S_2T
frame_clean  out  1  all 2T syndromes of the streaming frame are zero; valid while synd_valid=1
overrun  out  1  one-cycle pulse: a completed frame was dropped
frame_abort  out  1  one-cycle pulse: data_sof arrived before the current frame completed

Behaviour:
- Reset values: all accumulators, counters and bank = 0; all outputs 0.
- Root constants alpha^(FCR+j-1) are computed at elaboration from PRIM_POLY. One constant GF multiplier per syndrome; no runtime tables.
- Symbol counter cnt (0..N) advances only on data_valid. Non-valid cycles hold all state.
- data_valid & data_sof: S_j <= data_in for all j; cnt <= 1. If cnt was in 1..N-1, pulse frame_abort and discard the partial frame.
- data_valid & !data_sof & cnt in 1..N-1: S_j <= data_in ^ (S_j * alpha^(FCR+j-1)); cnt++.
- data_valid & !data_sof & cnt==0: symbol ignored (no frame open).
- Completion: the valid symbol taking cnt to N closes the frame. The post-update S_j values and the zero-OR flag are written to the bank on the next edge; cnt <= 0.
- Output FSM has two states, IDLE and STREAM.
  - IDLE -> STREAM on bank load. synd_valid rises 1 cycle after the Nth symbol is accepted, with synd_idx=0 and synd_out=S_1.
  - In STREAM, synd_out, synd_idx and synd_last hold until synd_valid & synd_ready, then the index increments. Output order is S_1..S_2T.
  - The handshake on synd_last returns the FSM to IDLE.
- Bank full at completion: the frame is dropped, overrun pulses, and the bank is not modified.
- Simultaneous completion and final handshake (synd_last & synd_ready): the bank frees and reloads on the same edge. FSM stays in STREAM with idx=0, and no overrun.
- Reset mid-frame or mid-stream: everything returns to reset values immediately. No partial output on deassertion.
- Back-to-back frames at full rate: sustained with no gaps, provided synd_ready is high for at least 2T of every N cycles.

Optional Feature:
SYND_ZERO_SKIP_EN
- Defined: a frame whose syndromes are all zero is not streamed. Instead, frame_clean pulses one cycle with synd_valid=0, 1 cycle after completion. The bank is never occupied, so such a frame cannot cause overrun.
- Undefined: every frame streams. frame_clean is a sideband, held for the whole stream of that frame.

Test Plan:
1. N=255, all symbols 0 -> 16 syndromes = 8'h00, frame_clean=1 on every beat, synd_last on idx 15, synd_valid 1 cycle after the 255th symbol.
2. All 0 except last symbol = 8'h5A (FCR=0) -> every S_j = 8'h5A, frame_clean=0.
3. All 0 except second-to-last = 8'h01 -> S_1..S_16 = 01,02,04,08,10,20,40,80,1D,3A,74,E8,CD,87,13,26.
4. synd_ready held low for 300 cycles while the next frame completes -> overrun pulses once, first bank unchanged, and its 16 values emerge intact after ready rises.
5. data_sof at cnt=100, then a full 255-symbol frame -> frame_abort one pulse, only the second frame's syndromes are output. Also: data_valid gaps of 3 cycles give results identical to the gap-free frame.
6. rst_n low at stream idx 7 -> all outputs 0 the same cycle. A following clean frame streams from idx 0. Repeat scenario 1 with SYND_ZERO_SKIP_EN defined -> no synd_valid, one frame_clean pulse.

Source files
------------

// File: rtl/rs_syndrome_engine_if.sv
// Symbol-input / syndrome-output bundle of the RS syndrome engine.
// slave = the engine, master = upstream symbol source plus downstream syndrome sink.
interface rs_syndrome_engine_if #(
   parameter int M  = 8,
   parameter int IW = 4
);
   logic          data_valid;
   logic          data_sof;
   logic [M-1:0]  data_in;
   logic          synd_valid;
   logic          synd_ready;
   logic [M-1:0]  synd_out;
   logic [IW-1:0] synd_idx;
   logic          synd_last;
   logic          frame_clean;
   logic          overrun;
   logic          frame_abort;

   // synd_out/synd_idx/synd_last are stable while synd_valid=1 and advance only
   // on a cycle where synd_valid & synd_ready are both high (that is the transfer).
   modport slave (
      input  data_valid, data_sof, data_in, synd_ready,
      output synd_valid, synd_out, synd_idx, synd_last, frame_clean, overrun, frame_abort
   );

   modport master (
      output data_valid, data_sof, data_in, synd_ready,
      input  synd_valid, synd_out, synd_idx, synd_last, frame_clean, overrun, frame_abort
   );
endinterface

// File: rtl/rs_syndrome_engine.sv
// Parametrised RS syndrome calculator: Horner accumulators, double-buffered bank, serial output.
// Optional macro SYND_ZERO_SKIP_EN: all-zero frames are not streamed, frame_clean pulses instead.
module rs_syndrome_engine #(
   parameter int         N         = 255,
   parameter int         K         = 239,
   parameter int         M         = 8,
   parameter int         FCR       = 0,
   parameter logic [M:0] PRIM_POLY = 9'h11D
) (
   input  logic               clk_in,
   input  logic               rst_n,
   rs_syndrome_engine_if.slave io,
   output logic               o_dbg_state
);
   localparam int T2 = N - K;
   localparam int IW = (T2 > 1) ? $clog2(T2) : 1;
   localparam int CW = $clog2(N + 1);

   generate
      if (T2 < 1 || K < 1 || N < 2 || N > (1 << M) - 1) begin : g_bad_params
         $error("rs_syndrome_engine: illegal N/K/M combination");
      end
   endgenerate

   function automatic logic [M-1:0] gf_xtime(input logic [M-1:0] a);
      return a[M-1] ? ((a << 1) ^ PRIM_POLY[M-1:0]) : (a << 1);
   endfunction

   function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
      logic [M-1:0] acc;
      logic [M-1:0] p;
      acc = '0;
      p   = a;
      for (int i = 0; i < M; i++) begin
         if (b[i]) acc = acc ^ p;
         p = gf_xtime(p);
      end
      return acc;
   endfunction

   function automatic logic [M-1:0] gf_alpha_pow(input int e);
      logic [M-1:0] v;
      v = M'(1);
      for (int i = 0; i < e % ((1 << M) - 1); i++) v = gf_xtime(v);
      return v;
   endfunction

   typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_t;

   logic [M-1:0]  r_s    [T2];
   logic [M-1:0]  r_bank [T2];
   logic [M-1:0]  w_next [T2];
   logic [CW-1:0] r_cnt;
   logic [IW-1:0] r_idx;
   state_t        r_state;
   logic          r_bank_clean;
   logic          r_overrun;
   logic          r_abort;
   logic          w_zero, w_open, w_done, w_hs, w_hs_last, w_free, w_skip, w_load, w_drop;

   // Root multipliers are constant, so each gf_mul collapses to an XOR network.
   for (genvar j = 0; j < T2; j++) begin : g_root
      localparam logic [M-1:0] ROOT = gf_alpha_pow(FCR + j);
      assign w_next[j] = io.data_in ^ gf_mul(r_s[j], ROOT);
   end

   always_comb begin
      w_zero = 1'b1;
      for (int j = 0; j < T2; j++) begin
         if (r_s[j] != '0) w_zero = 1'b0;
      end
   end

   assign w_open    = (r_cnt != '0) && (r_cnt < CW'(N));
   assign w_done    = (r_cnt == CW'(N));
   assign w_hs      = (r_state == STREAM) && io.synd_ready;
   assign w_hs_last = w_hs && (r_idx == IW'(T2 - 1));
   assign w_free    = (r_state == IDLE) || w_hs_last;
`ifdef SYND_ZERO_SKIP_EN
   assign w_skip    = w_zero;
`else
   assign w_skip    = 1'b0;
`endif
   assign w_load    = w_done && w_free && !w_skip;
   assign w_drop    = w_done && !w_free && !w_skip;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < T2; j++) r_s[j] <= '0;
         r_cnt   <= '0;
         r_abort <= 1'b0;
      end else begin
         r_abort <= 1'b0;
         if (io.data_valid && io.data_sof) begin
            for (int j = 0; j < T2; j++) r_s[j] <= io.data_in;
            r_cnt   <= CW'(1);
            r_abort <= w_open;
         end else if (io.data_valid && w_open) begin
            for (int j = 0; j < T2; j++) r_s[j] <= w_next[j];
            r_cnt <= r_cnt + CW'(1);
         end else if (w_done) begin
            r_cnt <= '0;
         end
      end
   end

   // A load on the same edge as the final transfer restarts the stream at idx 0.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_idx        <= '0;
         r_bank_clean <= 1'b0;
         r_overrun    <= 1'b0;
         for (int j = 0; j < T2; j++) r_bank[j] <= '0;
      end else begin
         r_overrun <= w_drop;
         if (w_load) begin
            r_state      <= STREAM;
            r_idx        <= '0;
            r_bank_clean <= w_zero;
            for (int j = 0; j < T2; j++) r_bank[j] <= r_s[j];
         end else if (w_hs_last) begin
            r_state <= IDLE;
            r_idx   <= '0;
         end else if (w_hs) begin
            r_idx <= r_idx + IW'(1);
         end
      end
   end

   assign io.synd_valid = (r_state == STREAM);
   assign io.synd_out   = r_bank[r_idx];
   assign io.synd_idx   = r_idx;
   assign io.synd_last  = (r_state == STREAM) && (r_idx == IW'(T2 - 1));
   assign io.overrun    = r_overrun;
   assign io.frame_abort = r_abort;
   assign o_dbg_state   = r_state;

`ifdef SYND_ZERO_SKIP_EN
   logic r_clean_pulse;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) r_clean_pulse <= 1'b0;
      else        r_clean_pulse <= w_done && w_skip;
   end

   // Streamed frames are never clean here, so the sideband term stays low.
   assign io.frame_clean = r_clean_pulse | ((r_state == STREAM) && r_bank_clean);
`else
   assign io.frame_clean = (r_state == STREAM) && r_bank_clean;
`endif
endmodule

// File: tb/tb_rs_syndrome_engine.sv
// Bench for rs_syndrome_engine at RS(255,239), FCR=0, PRIM_POLY=0x11D.
// Reference syndromes come from direct polynomial evaluation with log/antilog tables.
module tb_rs_syndrome_engine;
   localparam int N  = 255;
   localparam int K  = 239;
   localparam int M  = 8;
   localparam int T2 = N - K;
   localparam int IW = 4;

   logic clk_in = 1'b0;
   logic rst_n  = 1'b0;
   logic dbg_state;

   rs_syndrome_engine_if #(.M(M), .IW(IW)) sif ();

   rs_syndrome_engine #(.N(N), .K(K), .M(M), .FCR(0), .PRIM_POLY(9'h11D)) dut (
      .clk_in      (clk_in),
      .rst_n       (rst_n),
      .io          (sif.slave),
      .o_dbg_state (dbg_state)
   );

   always #5 clk_in = ~clk_in;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   logic [M-1:0] exp_t [256];
   int           log_t [256];
   logic [M-1:0] frm   [N];
   logic [M:0]   exp_q [$];
   logic [M-1:0] got_val   [$];
   logic [IW-1:0] got_idx  [$];
   logic         got_last  [$];
   logic         got_clean [$];
   int  n_overrun = 0, n_abort = 0, n_clean_pulse = 0;
   int  first_valid_cyc = 0, clean_pulse_cyc = 0, acc_cyc = 0;
   logic prev_valid = 1'b0;
   bit  rand_ready = 1'b0;

   // Monitor: record every transfer and every sideband pulse, away from the active edge.
   always @(negedge clk_in) begin
      if (rst_n) begin
         if (sif.synd_valid && sif.synd_ready) begin
            got_val.push_back(sif.synd_out);
            got_idx.push_back(sif.synd_idx);
            got_last.push_back(sif.synd_last);
            got_clean.push_back(sif.frame_clean);
         end
         if (sif.overrun) n_overrun <= n_overrun + 1;
         if (sif.frame_abort) n_abort <= n_abort + 1;
         if (sif.frame_clean && !sif.synd_valid) begin
            n_clean_pulse   <= n_clean_pulse + 1;
            clean_pulse_cyc <= cyc;
         end
         if (sif.synd_valid && !prev_valid) first_valid_cyc <= cyc;
      end
      prev_valid <= sif.synd_valid;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk_in);
      #1;
      if (rand_ready) sif.synd_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send_frame(input int nsym, input int gap);
      for (int i = 0; i < nsym; i++) begin
         tick();
         sif.data_valid = 1'b1;
         sif.data_sof   = (i == 0);
         sif.data_in    = frm[i];
         if (i < nsym - 1) begin
            for (int g = 0; g < gap; g++) begin
               tick();
               sif.data_valid = 1'b0;
               sif.data_sof   = 1'($urandom_range(0, 1));
               sif.data_in    = M'($urandom);
            end
         end
      end
   endtask

   task automatic end_frame();
      tick();
      acc_cyc        = cyc;
      sif.data_valid = 1'b0;
      sif.data_sof   = 1'b0;
   endtask

   task automatic fill_random();
      for (int i = 0; i < N; i++) frm[i] = M'($urandom);
   endtask

   task automatic fill_zero();
      for (int i = 0; i < N; i++) frm[i] = '0;
   endtask

   // S_j = r(alpha^(j-1)) with r_i the coefficient of x^(N-1-i).
   task automatic model_push();
      logic [M-1:0] s [T2];
      bit clean;
      clean = 1'b1;
      for (int j = 0; j < T2; j++) begin
         s[j] = '0;
         for (int i = 0; i < N; i++) begin
            if (frm[i] != '0) s[j] = s[j] ^ exp_t[(log_t[frm[i]] + j * (N - 1 - i)) % 255];
         end
         if (s[j] != '0) clean = 1'b0;
      end
`ifdef SYND_ZERO_SKIP_EN
      if (!clean) for (int j = 0; j < T2; j++) exp_q.push_back({clean, s[j]});
`else
      for (int j = 0; j < T2; j++) exp_q.push_back({clean, s[j]});
`endif
   endtask

   task automatic wait_beats(input int n, output bit ok);
      for (int t = 0; t < 3000 && got_val.size() < n; t++) tick();
      ok = (got_val.size() >= n);
   endtask

   task automatic flush_queues();
      exp_q.delete();
      got_val.delete();
      got_idx.delete();
      got_last.delete();
      got_clean.delete();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [17:0] obs;
      repeat (3) tick();
      obs = {sif.synd_valid, sif.synd_out, sif.synd_idx, sif.synd_last, sif.frame_clean,
             sif.overrun, sif.frame_abort, dbg_state};
      total++;
      if (obs !== 18'h0) begin
         bad++;
         $display("FAIL reset_outputs got=%h want=%h", obs, 18'h0);
      end
      rst_n = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_zero_frame();
      bit ok;
      logic [M+IW+1:0] obs, expv;
      int c0;
      fill_zero();
      c0 = n_clean_pulse;
`ifndef SYND_ZERO_SKIP_EN
      for (int j = 0; j < T2; j++) exp_q.push_back({1'b1, 8'h00});
`endif
      send_frame(N, 0);
      end_frame();
`ifdef SYND_ZERO_SKIP_EN
      repeat (20) tick();
      total++;
      if (n_clean_pulse - c0 !== 1) begin
         bad++;
         $display("FAIL zero_clean_pulses got=%0d want=1", n_clean_pulse - c0);
      end
      total++;
      if (clean_pulse_cyc !== acc_cyc + 1) begin
         bad++;
         $display("FAIL zero_clean_cycle got=%0d want=%0d", clean_pulse_cyc, acc_cyc + 1);
      end
      total++;
      if (got_val.size() !== 0) begin
         bad++;
         $display("FAIL zero_no_stream got=%0d beats want=0", got_val.size());
      end
`else
      wait_beats(T2, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL zero_timeout got=%0d beats want=%0d", got_val.size(), T2);
      end
      total++;
      if (first_valid_cyc !== acc_cyc + 1) begin
         bad++;
         $display("FAIL zero_latency got=%0d want=%0d", first_valid_cyc, acc_cyc + 1);
      end
      for (int b = 0; b < T2 && got_val.size() > 0; b++) begin
         logic [M:0] e;
         e    = exp_q.pop_front();
         obs  = {got_val.pop_front(), got_idx.pop_front(), got_last.pop_front(), got_clean.pop_front()};
         expv = {e[M-1:0], IW'(b), 1'(b == T2 - 1), e[M]};
         total++;
         if (obs !== expv) begin
            bad++;
            $display("FAIL zero_beat%0d got=%h want=%h", b, obs, expv);
         end
      end
`endif
      flush_queues();
   endtask

   task automatic test_known_vectors();
      logic [M-1:0] unit_tbl [T2] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                      8'h1D, 8'h3A, 8'h74, 8'hE8, 8'hCD, 8'h87, 8'h13, 8'h26};
      bit ok;
      logic [M+IW+1:0] obs, expv;
      for (int v = 0; v < 2; v++) begin
         fill_zero();
         if (v == 0) frm[N-1] = 8'h5A;
         else        frm[N-2] = 8'h01;
         for (int j = 0; j < T2; j++) exp_q.push_back({1'b0, (v == 0) ? 8'h5A : unit_tbl[j]});
         send_frame(N, 0);
         end_frame();
         wait_beats(T2, ok);
         total++;
         if (!ok) begin
            bad++;
            $display("FAIL known%0d_timeout got=%0d beats want=%0d", v, got_val.size(), T2);
         end
         for (int b = 0; b < T2 && got_val.size() > 0; b++) begin
            logic [M:0] e;
            e    = exp_q.pop_front();
            obs  = {got_val.pop_front(), got_idx.pop_front(), got_last.pop_front(), got_clean.pop_front()};
            expv = {e[M-1:0], IW'(b), 1'(b == T2 - 1), e[M]};
            total++;
            if (obs !== expv) begin
               bad++;
               $display("FAIL known%0d_beat%0d got=%h want=%h", v, b, obs, expv);
            end
         end
         flush_queues();
      end
   endtask

   task automatic test_random_gaps();
      bit ok;
      logic [M+IW+1:0] obs, expv;
      for (int r = 0; r < 2; r++) begin
         fill_random();
         model_push();
         model_push();
         send_frame(N, 0);
         end_frame();
         repeat (5) tick();
         send_frame(N, 3);
         end_frame();
         wait_beats(exp_q.size(), ok);
         total++;
         if (!ok) begin
            bad++;
            $display("FAIL gaps%0d_timeout got=%0d beats want=%0d", r, got_val.size(), exp_q.size());
         end
         for (int b = 0; exp_q.size() > 0 && got_val.size() > 0; b++) begin
            logic [M:0] e;
            e    = exp_q.pop_front();
            obs  = {got_val.pop_front(), got_idx.pop_front(), got_last.pop_front(), got_clean.pop_front()};
            expv = {e[M-1:0], IW'(b % T2), 1'(b % T2 == T2 - 1), e[M]};
            total++;
            if (obs !== expv) begin
               bad++;
               $display("FAIL gaps%0d_beat%0d got=%h want=%h", r, b, obs, expv);
            end
         end
         flush_queues();
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int o0, nexp;
      logic [M+IW+1:0] obs, expv;
      o0 = n_overrun;
      rand_ready = 1'b1;
      for (int f = 0; f < 4; f++) begin
         fill_random();
         model_push();
         send_frame(N, 0);
      end
      end_frame();
      nexp = exp_q.size();
      wait_beats(nexp, ok);
      rand_ready     = 1'b0;
      sif.synd_ready = 1'b1;
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL b2b_timeout got=%0d beats want=%0d", got_val.size(), nexp);
      end
      for (int b = 0; exp_q.size() > 0 && got_val.size() > 0; b++) begin
         logic [M:0] e;
         e    = exp_q.pop_front();
         obs  = {got_val.pop_front(), got_idx.pop_front(), got_last.pop_front(), got_clean.pop_front()};
         expv = {e[M-1:0], IW'(b % T2), 1'(b % T2 == T2 - 1), e[M]};
         total++;
         if (obs !== expv) begin
            bad++;
            $display("FAIL b2b_beat%0d got=%h want=%h", b, obs, expv);
         end
      end
      total++;
      if (n_overrun - o0 !== 0) begin
         bad++;
         $display("FAIL b2b_overrun got=%0d want=0", n_overrun - o0);
      end
      flush_queues();
   endtask

   task automatic test_overrun();
      bit ok;
      int o0, t0;
      logic [M+IW+1:0] obs, expv;
      o0 = n_overrun;
      sif.synd_ready = 1'b0;
      fill_random();
      model_push();
      send_frame(N, 0);
      end_frame();
      t0 = acc_cyc;
      fill_random();
      send_frame(N, 0);
      end_frame();
      while (cyc < t0 + 300) tick();
      total++;
      if (n_overrun - o0 !== 1) begin
         bad++;
         $display("FAIL overrun_pulses got=%0d want=1", n_overrun - o0);
      end
      total++;
      if (got_val.size() !== 0) begin
         bad++;
         $display("FAIL overrun_stalled got=%0d beats want=0", got_val.size());
      end
      sif.synd_ready = 1'b1;
      wait_beats(T2, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL overrun_timeout got=%0d beats want=%0d", got_val.size(), T2);
      end
      for (int b = 0; b < T2 && got_val.size() > 0; b++) begin
         logic [M:0] e;
         e    = exp_q.pop_front();
         obs  = {got_val.pop_front(), got_idx.pop_front(), got_last.pop_front(), got_clean.pop_front()};
         expv = {e[M-1:0], IW'(b), 1'(b == T2 - 1), e[M]};
         total++;
         if (obs !== expv) begin
            bad++;
            $display("FAIL overrun_beat%0d got=%h want=%h", b, obs, expv);
         end
      end
      repeat (40) tick();
      total++;
      if (got_val.size() !== 0 || sif.synd_valid !== 1'b0) begin
         bad++;
         $display("FAIL overrun_dropped got=%0d beats valid=%b want=0 beats valid=0",
                  got_val.size(), sif.synd_valid);
      end
      flush_queues();
   endtask

   task automatic test_abort();
      bit ok;
      int a0;
      logic [M+IW+1:0] obs, expv;
      a0 = n_abort;
      fill_random();
      send_frame(100, 0);
      fill_random();
      model_push();
      send_frame(N, 0);
      end_frame();
      wait_beats(T2, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL abort_timeout got=%0d beats want=%0d", got_val.size(), T2);
      end
      for (int b = 0; b < T2 && got_val.size() > 0; b++) begin
         logic [M:0] e;
         e    = exp_q.pop_front();
         obs  = {got_val.pop_front(), got_idx.pop_front(), got_last.pop_front(), got_clean.pop_front()};
         expv = {e[M-1:0], IW'(b), 1'(b == T2 - 1), e[M]};
         total++;
         if (obs !== expv) begin
            bad++;
            $display("FAIL abort_beat%0d got=%h want=%h", b, obs, expv);
         end
      end
      repeat (30) tick();
      total++;
      if (n_abort - a0 !== 1 || got_val.size() !== 0) begin
         bad++;
         $display("FAIL abort_pulses got=%0d extra_beats=%0d want=1 extra_beats=0",
                  n_abort - a0, got_val.size());
      end
      flush_queues();
   endtask

   task automatic test_reset_mid_stream();
      bit ok;
      logic [17:0] obs;
      logic [M+IW+1:0] o2, expv;
      sif.synd_ready = 1'b1;
      fill_random();
      send_frame(N, 0);
      end_frame();
      for (int t = 0; t < 300 && got_val.size() < 8; t++) begin
         @(negedge clk_in);
         #1;
      end
      total++;
      if (sif.synd_idx !== IW'(7) || sif.synd_valid !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_pre_idx got=%0d valid=%b want=7 valid=1", sif.synd_idx, sif.synd_valid);
      end
      rst_n = 1'b0;
      #1;
      obs = {sif.synd_valid, sif.synd_out, sif.synd_idx, sif.synd_last, sif.frame_clean,
             sif.overrun, sif.frame_abort, dbg_state};
      total++;
      if (obs !== 18'h0) begin
         bad++;
         $display("FAIL rstmid_outputs got=%h want=%h", obs, 18'h0);
      end
      repeat (3) tick();
      rst_n = 1'b1;
      flush_queues();
      repeat (10) tick();
      total++;
      if (sif.synd_valid !== 1'b0 || got_val.size() !== 0) begin
         bad++;
         $display("FAIL rstmid_no_partial got valid=%b beats=%0d want valid=0 beats=0",
                  sif.synd_valid, got_val.size());
      end
      fill_zero();
`ifdef SYND_ZERO_SKIP_EN
      send_frame(N, 0);
      end_frame();
      repeat (20) tick();
      total++;
      if (got_val.size() !== 0 || clean_pulse_cyc !== acc_cyc + 1) begin
         bad++;
         $display("FAIL rstmid_clean_skip got beats=%0d pulse_cyc=%0d want beats=0 pulse_cyc=%0d",
                  got_val.size(), clean_pulse_cyc, acc_cyc + 1);
      end
`else
      for (int j = 0; j < T2; j++) exp_q.push_back({1'b1, 8'h00});
      send_frame(N, 0);
      end_frame();
      wait_beats(T2, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL rstmid_timeout got=%0d beats want=%0d", got_val.size(), T2);
      end
      for (int b = 0; b < T2 && got_val.size() > 0; b++) begin
         logic [M:0] e;
         e    = exp_q.pop_front();
         o2   = {got_val.pop_front(), got_idx.pop_front(), got_last.pop_front(), got_clean.pop_front()};
         expv = {e[M-1:0], IW'(b), 1'(b == T2 - 1), e[M]};
         total++;
         if (o2 !== expv) begin
            bad++;
            $display("FAIL rstmid_beat%0d got=%h want=%h", b, o2, expv);
         end
      end
`endif
      flush_queues();
   endtask

   initial begin
      logic [8:0] x;
      x = 9'h001;
      for (int i = 0; i < 255; i++) begin
         exp_t[i]     = x[7:0];
         log_t[x[7:0]] = i;
         x = x << 1;
         if (x[8]) x = x ^ 9'h11D;
      end
      exp_t[255] = 8'h01;
      log_t[0]   = 0;

      sif.data_valid = 1'b0;
      sif.data_sof   = 1'b0;
      sif.data_in    = '0;
      sif.synd_ready = 1'b1;

      test_reset();
      test_zero_frame();
      test_known_vectors();
      test_random_gaps();
      test_back_to_back();
      test_overrun();
      test_abort();
      test_reset_mid_stream();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
